fft_bfly_scheduler: RTL and testbench

- Initiator side of the radix-2 butterfly interface.
- Runs an in-place decimation-in-time FFT of 2^cfg_log2n points over a dual-port data RAM, stage by stage.
- Per butterfly: reads the operand pair and the twiddle, drives `butterfly_radix2` (enable/operands/twiddle), then writes its y0/y1 back when valid returns.
- Sits between the sample RAM, the twiddle ROM and the datapath butterfly in MultimodeFFT.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_addr_gen.sv | 68 ++++++
 rtl/fft_bfly_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_fft_bfly_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT butterfly scheduler.
//   FFT_WIDTH / FFT_CWIDTH : component and packed complex widths ({re, im}).
//   fft_state_t            : scheduler FSM encoding (IDLE, ISSUE, DRAIN, DONE).
//   sat_neg()              : two's-complement negate that maps the most
//                            negative value to the most positive one.
package fft_pkg;

  localparam int FFT_WIDTH  = 16;
  localparam int FFT_CWIDTH = 2 * FFT_WIDTH;

  localparam logic [FFT_WIDTH-1:0] Q_MIN = {1'b1, {(FFT_WIDTH-1){1'b0}}};
  localparam logic [FFT_WIDTH-1:0] Q_MAX = {1'b0, {(FFT_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fft_state_t;

  function automatic logic [FFT_WIDTH-1:0] sat_neg(input logic [FFT_WIDTH-1:0] v);
    if (v == Q_MIN) return Q_MAX;
    return (~v) + FFT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Stage / butterfly counters for an in-place radix-2 DIT FFT.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   clear           : restart at stage 0, butterfly 0
//   step            : advance to the next butterfly (wraps to 0 after last_k)
//   next_stage      : advance the stage counter
//   log2n           : current transform size (1..LOG2N_MAX)
//   addr_a, addr_b  : operand pair addresses for the current butterfly
//   tw_addr         : twiddle ROM address (ROM sized for 2^LOG2N_MAX points)
//   last_k          : current butterfly is the last of its stage
//   last_stage      : current stage is the final one
module fft_addr_gen #(
  parameter int LOG2N_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   step,
  input  logic                   next_stage,
  input  logic [3:0]             log2n,
  output logic [LOG2N_MAX-1:0]   addr_a,
  output logic [LOG2N_MAX-1:0]   addr_b,
  output logic [LOG2N_MAX-2:0]   tw_addr,
  output logic                   last_k,
  output logic                   last_stage
);

  localparam int AW = LOG2N_MAX;

  logic [AW-2:0] k;
  logic [3:0]    stage;

  logic [AW-1:0] k_ext;
  logic [AW-1:0] span;
  logic [AW-1:0] pos;
  logic [AW-1:0] k_max;
  logic [AW-1:0] tw_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k     <= '0;
      stage <= '0;
    end else if (clear) begin
      k     <= '0;
      stage <= '0;
    end else begin
      if (step) k <= last_k ? '0 : k + (AW-1)'(1);
      if (next_stage) stage <= stage + 4'd1;
    end
  end

  // Butterfly k of stage s pairs addr_a with addr_a + 2^s: the low s bits of
  // k select the position inside a group, the remaining bits the group.
  always_comb begin
    k_ext   = {1'b0, k};
    span    = AW'(1) << stage;
    pos     = k_ext & (span - AW'(1));
    addr_a  = ((k_ext >> stage) << (stage + 4'd1)) | pos;
    addr_b  = addr_a + span;
    // pos < 2^s, so the shifted value always fits in LOG2N_MAX-1 bits.
    tw_full = pos << (4'(LOG2N_MAX - 1) - stage);
    tw_addr = tw_full[AW-2:0];
    k_max   = (AW'(1) << (log2n - 4'd1)) - AW'(1);
    last_k  = (k_ext == k_max);
    last_stage = (stage == (log2n - 4'd1));
  end

endmodule

// File: rtl/fft_bfly_scheduler.sv
// Initiator side of the radix-2 butterfly interface: runs an in-place DIT FFT
// of 2^cfg_log2n points over a dual-port RAM, stage by stage.
// Configuration macro: FFT_BFLY_SCHED_IFFT_EN -- when defined, `inverse`
// conjugates the twiddles (saturating negate of the imaginary part); when
// undefined `inverse` is ignored and bf_tw is tw_data.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   start, cfg_log2n, inverse   : transform request (sampled when idle)
//   busy, done, err             : status (done = 1-cycle pulse, err sticky)
//   rd_en, rd_addr_a/b, rd_data_a/b : RAM read port (1-cycle latency)
//   tw_addr, tw_data            : twiddle ROM (1-cycle latency)
//   bf_enable, bf_x0/x1/tw      : butterfly drive
//   bf_y0/y1, bf_valid          : butterfly results, BFLY_LAT after bf_enable
//   wr_en, wr_addr_a/b, wr_data_a/b : RAM write port
//   fsm_state                   : scheduler state, for observation
// WIDTH must equal fft_pkg::FFT_WIDTH (the negate helper is sized from it).
module fft_bfly_scheduler
  import fft_pkg::*;
#(
  parameter int WIDTH     = FFT_WIDTH,
  parameter int LOG2N_MAX = 4,
  parameter int BFLY_LAT  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [3:0]             cfg_log2n,
  input  logic                   inverse,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   rd_en,
  output logic [LOG2N_MAX-1:0]   rd_addr_a,
  output logic [LOG2N_MAX-1:0]   rd_addr_b,
  input  logic [2*WIDTH-1:0]     rd_data_a,
  input  logic [2*WIDTH-1:0]     rd_data_b,
  output logic [LOG2N_MAX-2:0]   tw_addr,
  input  logic [2*WIDTH-1:0]     tw_data,
  output logic                   bf_enable,
  output logic [2*WIDTH-1:0]     bf_x0,
  output logic [2*WIDTH-1:0]     bf_x1,
  output logic [2*WIDTH-1:0]     bf_tw,
  input  logic [2*WIDTH-1:0]     bf_y0,
  input  logic [2*WIDTH-1:0]     bf_y1,
  input  logic                   bf_valid,
  output logic                   wr_en,
  output logic [LOG2N_MAX-1:0]   wr_addr_a,
  output logic [LOG2N_MAX-1:0]   wr_addr_b,
  output logic [2*WIDTH-1:0]     wr_data_a,
  output logic [2*WIDTH-1:0]     wr_data_b,
  output fft_state_t             fsm_state
);

  localparam int CW = 2 * WIDTH;
  localparam int AW = LOG2N_MAX;

  // Handshake: there is no back-pressure. bf_enable is a one-cycle request
  // and the butterfly must answer with bf_valid exactly BFLY_LAT cycles later;
  // a missing answer sets err and that write is dropped, while a bf_valid
  // with no outstanding request is ignored.

  fft_state_t state, state_nxt;
  logic [3:0] log2n_q, log2n_clamped;
  logic       start_acc;

  logic       gen_clear, gen_step, gen_next;
  logic [AW-1:0] gen_a, gen_b;
  logic [AW-2:0] gen_tw;
  logic       last_k, last_stage;

  // In-flight tracker: entry 0 is the bf_enable cycle, entry BFLY_LAT the
  // cycle whose results are written back.
  logic [BFLY_LAT:0] pv;
  logic [AW-1:0]     pa [BFLY_LAT+1];
  logic [AW-1:0]     pb [BFLY_LAT+1];
  logic [BFLY_LAT:0] head_mask;
  logic              head_v, head_miss, drain_ok;
  logic [CW-1:0]     tw_eff;

  assign start_acc = (state == ST_IDLE) && start;
  assign head_mask = (BFLY_LAT+1)'(1) << BFLY_LAT;
  assign head_v    = pv[BFLY_LAT];
  assign head_miss = head_v && !bf_valid;
  // The head entry retires this cycle, so only younger entries hold a stage.
  assign drain_ok  = ((pv & ~head_mask) == '0);
  assign fsm_state = state;

  always_comb begin
    if (cfg_log2n == 4'd0)                  log2n_clamped = 4'd1;
    else if (cfg_log2n > 4'(LOG2N_MAX))     log2n_clamped = 4'(LOG2N_MAX);
    else                                    log2n_clamped = cfg_log2n;
  end

  fft_addr_gen #(.LOG2N_MAX(LOG2N_MAX)) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (gen_clear),
    .step       (gen_step),
    .next_stage (gen_next),
    .log2n      (log2n_q),
    .addr_a     (gen_a),
    .addr_b     (gen_b),
    .tw_addr    (gen_tw),
    .last_k     (last_k),
    .last_stage (last_stage)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      log2n_q <= 4'd1;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) log2n_q <= log2n_clamped;
      if (start_acc)      err <= 1'b0;
      else if (head_miss) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i <= BFLY_LAT; i++) begin
        pa[i] <= '0;
        pb[i] <= '0;
      end
    end else begin
      pv[0] <= rd_en;
      pa[0] <= rd_addr_a;
      pb[0] <= rd_addr_b;
      for (int i = 1; i <= BFLY_LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gen_clear = 1'b0;
    gen_step  = 1'b0;
    gen_next  = 1'b0;
    rd_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          gen_clear = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        busy     = 1'b1;
        rd_en    = 1'b1;
        gen_step = 1'b1;
        if (last_k) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_ok) begin
          if (last_stage) begin
            state_nxt = ST_DONE;
          end else begin
            gen_next  = 1'b1;
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef FFT_BFLY_SCHED_IFFT_EN
  logic inv_q;

  always_ff @(posedge clk) begin
    if (!rst_n)         inv_q <= 1'b0;
    else if (start_acc) inv_q <= inverse;
  end

  assign tw_eff = inv_q ? {tw_data[CW-1:WIDTH], sat_neg(tw_data[WIDTH-1:0])} : tw_data;
`else
  logic unused_inverse;
  assign unused_inverse = inverse;
  assign tw_eff = tw_data;
`endif

  // Address and data buses are forced to 0 whenever their strobe is low.
  assign rd_addr_a = rd_en ? gen_a : '0;
  assign rd_addr_b = rd_en ? gen_b : '0;
  assign tw_addr   = rd_en ? gen_tw : '0;

  assign bf_enable = pv[0];
  assign bf_x0     = bf_enable ? rd_data_a : '0;
  assign bf_x1     = bf_enable ? rd_data_b : '0;
  assign bf_tw     = bf_enable ? tw_eff : '0;

  assign wr_en     = head_v && bf_valid;
  assign wr_addr_a = wr_en ? pa[BFLY_LAT] : '0;
  assign wr_addr_b = wr_en ? pb[BFLY_LAT] : '0;
  assign wr_data_a = wr_en ? bf_y0 : '0;
  assign wr_data_b = wr_en ? bf_y1 : '0;

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// Bench for fft_bfly_scheduler: behavioural RAM, twiddle ROM and butterfly,
// plus an array-level reference FFT that predicts every read, butterfly
// drive and write, the completion cycle and the final RAM image.
module tb_fft_bfly_scheduler;
  import fft_pkg::*;

  localparam int WIDTH = 16, LOG2N_MAX = 4, BFLY_LAT = 1, CW = 32;
`ifdef FFT_BFLY_SCHED_IFFT_EN
  localparam bit IFFT_EN = 1'b1;
`else
  localparam bit IFFT_EN = 1'b0;
`endif

  logic clk, rst_n, start, inverse, busy, done, err, rd_en;
  logic [3:0] cfg_log2n;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [2:0] tw_addr;
  logic [CW-1:0] rd_data_a, rd_data_b, tw_data, bf_x0, bf_x1, bf_tw, bf_y0, bf_y1;
  logic [CW-1:0] wr_data_a, wr_data_b;
  logic bf_enable, bf_valid, wr_en;
  fft_state_t fsm_state;

  fft_bfly_scheduler #(.WIDTH(WIDTH), .LOG2N_MAX(LOG2N_MAX), .BFLY_LAT(BFLY_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_log2n(cfg_log2n), .inverse(inverse),
    .busy(busy), .done(done), .err(err), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .tw_addr(tw_addr), .tw_data(tw_data), .bf_enable(bf_enable),
    .bf_x0(bf_x0), .bf_x1(bf_x1), .bf_tw(bf_tw), .bf_y0(bf_y0), .bf_y1(bf_y1), .bf_valid(bf_valid),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural memories and butterfly ----------------
  logic [CW-1:0] ram [16];
  logic [CW-1:0] init_mem [16];
  logic [CW-1:0] rom [8];
  logic load_req = 1'b0;
  int   en_cnt = 0;
  int   drop_n = 0;
  logic [CW-1:0] y0t, y1t;

  function automatic void bfly(input logic [CW-1:0] x0, x1, w, output logic [CW-1:0] y0, y1);
    longint x0r, x0i, x1r, x1i, wre, wim, tr, ti;
    x0r = longint'($signed(x0[31:16])); x0i = longint'($signed(x0[15:0]));
    x1r = longint'($signed(x1[31:16])); x1i = longint'($signed(x1[15:0]));
    wre = longint'($signed(w[31:16]));  wim = longint'($signed(w[15:0]));
    tr = (x1r * wre - x1i * wim) >>> 15;
    ti = (x1r * wim + x1i * wre) >>> 15;
    y0 = {16'(x0r + tr), 16'(x0i + ti)};
    y1 = {16'(x0r - tr), 16'(x0i - ti)};
  endfunction

  always @(posedge clk) begin
    rd_data_a <= ram[rd_addr_a];
    rd_data_b <= ram[rd_addr_b];
    tw_data   <= rom[tw_addr];
    if (load_req) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_mem[i];
    end else if (wr_en) begin
      ram[wr_addr_a] <= wr_data_a;
      ram[wr_addr_b] <= wr_data_b;
    end
  end

  always @(posedge clk) begin
    bf_valid <= 1'b0;
    if (load_req) en_cnt <= 0;
    else if (bf_enable === 1'b1) begin
      en_cnt <= en_cnt + 1;
      bfly(bf_x0, bf_x1, bf_tw, y0t, y1t);
      bf_y0    <= y0t;
      bf_y1    <= y1t;
      bf_valid <= (en_cnt + 1 != drop_n);
    end
  end

  // ---------------- scoreboard ----------------
  int n_total = 0, n_bad = 0;
  logic [10:0] exp_rd_q [$];
  logic [95:0] exp_bf_q [$];
  logic [71:0] exp_q [$];
  logic [CW-1:0] exp_mem [16];
  logic [10:0] rd_seen [$];
  logic [CW-1:0] tw_seen [$];
  int cyc = 0, t0 = 0, done_cnt = 0, done_rel = -1, wr_any = 0;
  bit mon_en = 1'b0;
  logic busy_at_done;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc - t0);
    end
  endtask

  function automatic logic [CW-1:0] tw_eff(input logic [CW-1:0] w, input bit inv);
    int im;
    if (inv && IFFT_EN) begin
      im = -int'($signed(w[15:0]));
      if (im > 32767) im = 32767;
      return {w[31:16], 16'(im)};
    end
    return w;
  endfunction

  // Reference: classic DIT loops over stages, groups and in-group positions.
  task automatic run_model(input int lg, input bit inv, input int drop);
    logic [CW-1:0] m [16];
    logic [CW-1:0] w, y0, y1;
    int n, span, a, b, t, cnt;
    exp_rd_q.delete(); exp_bf_q.delete(); exp_q.delete();
    for (int i = 0; i < 16; i++) m[i] = init_mem[i];
    n = 1 << lg;
    cnt = 0;
    for (int s = 0; s < lg; s++) begin
      span = 1 << s;
      for (int g = 0; g < n; g += 2 * span) begin
        for (int j = 0; j < span; j++) begin
          a = g + j; b = a + span; t = j * (8 / span);
          w = tw_eff(rom[t], inv);
          exp_rd_q.push_back({4'(a), 4'(b), 3'(t)});
          exp_bf_q.push_back({m[a], m[b], w});
          bfly(m[a], m[b], w, y0, y1);
          cnt++;
          if (cnt != drop) begin
            exp_q.push_back({4'(a), 4'(b), y0, y1});
            m[a] = y0; m[b] = y1;
          end
        end
      end
    end
    for (int i = 0; i < 16; i++) exp_mem[i] = m[i];
  endtask

  // One clock period; observe outputs at the falling edge.
  task automatic tick();
    logic [10:0] e11;
    logic [95:0] e96;
    logic [71:0] e72;
    @(negedge clk);
    cyc++;
    if (wr_en) wr_any++;
    if (mon_en) begin
      if (rd_en) begin
        rd_seen.push_back({rd_addr_a, rd_addr_b, tw_addr});
        if (exp_rd_q.size() == 0) check("rd_extra", 1, 0);
        else begin e11 = exp_rd_q.pop_front(); check("rd_addr", {rd_addr_a, rd_addr_b, tw_addr}, e11); end
      end
      if (bf_enable) begin
        tw_seen.push_back(bf_tw);
        if (exp_bf_q.size() == 0) check("bf_extra", 1, 0);
        else begin e96 = exp_bf_q.pop_front(); check("bf_drive", {bf_x0, bf_x1, bf_tw}, e96); end
      end
      if (wr_en) begin
        if (exp_q.size() == 0) check("wr_extra", 1, 0);
        else begin e72 = exp_q.pop_front(); check("wr", {wr_addr_a, wr_addr_b, wr_data_a, wr_data_b}, e72); end
      end
      if (done) begin
        done_cnt++;
        done_rel = cyc - t0;
        busy_at_done = busy;
      end
    end
  endtask

  task automatic load_mem();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 16; i++) init_mem[i] = $urandom;
  endtask

  task automatic begin_run(input logic [3:0] cfg, input bit inv, input int drop, output int lg);
    lg = (cfg == 0) ? 1 : (cfg > 4) ? 4 : int'(cfg);
    load_mem();
    run_model(lg, inv, drop);
    drop_n = drop;
    done_cnt = 0; done_rel = -1;
    rd_seen.delete(); tw_seen.delete();
    start = 1'b1; cfg_log2n = cfg; inverse = inv;
    t0 = cyc; mon_en = 1'b1;
    tick();
    start = 1'b0;
    check("busy_c1", busy, 1);
    check("err_clr_c1", err, 0);
  endtask

  task automatic run_fft(input logic [3:0] cfg, input bit inv, input int drop, input int p1, input int p2);
    int lg, per, guard;
    begin_run(cfg, inv, drop, lg);
    per = (1 << lg) / 2 + 1 + BFLY_LAT;
    guard = 0;
    while (done_cnt == 0 && guard < 200) begin
      tick();
      start = ((cyc - t0) == p1) || ((cyc - t0) == p2);
      guard++;
    end
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("done_once", done_cnt, 1);
    check("done_cycle", done_rel, lg * per + 1);
    check("busy_at_done", busy_at_done, 0);
    check("rd_left", exp_rd_q.size(), 0);
    check("bf_left", exp_bf_q.size(), 0);
    check("wr_left", exp_q.size(), 0);
    check("err_end", err, (drop != 0));
    for (int i = 0; i < (1 << lg); i++) check($sformatf("mem[%0d]", i), ram[i], exp_mem[i]);
    mon_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int s1a [4] = '{0, 1, 4, 5};
  int s1t [4] = '{0, 4, 0, 4};
  int s2t [4] = '{0, 2, 4, 6};

  initial begin
    int lg, guard;
    rst_n = 1'b0; start = 1'b0; cfg_log2n = 4'd0; inverse = 1'b0;
    for (int i = 0; i < 8; i++) rom[i] = $urandom;
    for (int i = 0; i < 16; i++) init_mem[i] = '0;
    for (int i = 0; i < 3; i++) tick();

    // outputs during reset
    check("rst_status", {busy, done, err, rd_en, bf_enable, wr_en}, 0);
    check("rst_rd_bus", {rd_addr_a, rd_addr_b, tw_addr}, 0);
    check("rst_bf_bus", {bf_x0, bf_x1, bf_tw}, 0);
    check("rst_wr_bus", {wr_addr_a, wr_addr_b, wr_data_a, wr_data_b}, 0);
    rst_n = 1'b1;
    tick();

    // impulse, N = 8
    for (int i = 0; i < 16; i++) init_mem[i] = '0;
    init_mem[0] = {16'sd16384, 16'sd0};
    run_fft(4'd3, 1'b0, 0, -1, -1);
    for (int i = 0; i < 8; i++) check("impulse_word", ram[i], {16'sd16384, 16'sd0});
    if (rd_seen.size() < 12) check("rd_seen_count", rd_seen.size(), 12);
    else begin
      for (int i = 0; i < 4; i++) begin
        check("stage1_seq", rd_seen[4 + i], {4'(s1a[i]), 4'(s1a[i] + 2), 3'(s1t[i])});
        check("stage2_seq", rd_seen[8 + i], {4'(i), 4'(i + 4), 3'(s2t[i])});
      end
    end

    // start pulses while busy are ignored
    rand_mem();
    run_fft(4'd3, 1'b0, 0, 5, 12);

    // twiddle conjugation corner values, N = 4
    rom[0] = {16'sd0, -16'sd32767};
    rom[4] = {16'sd0, 16'h8000};
    rand_mem();
    run_fft(4'd2, 1'b1, 0, -1, -1);
    if (tw_seen.size() < 4) check("tw_seen_count", tw_seen.size(), 4);
    else begin
      check("tw_neg_32767", tw_seen[2], IFFT_EN ? 32'h0000_7FFF : 32'h0000_8001);
      check("tw_neg_32768", tw_seen[3], IFFT_EN ? 32'h0000_7FFF : 32'h0000_8000);
    end
    for (int i = 0; i < 8; i++) rom[i] = $urandom;

    // missing third bf_valid
    rand_mem();
    run_fft(4'd3, 1'b0, 3, -1, -1);
    for (int i = 0; i < 4; i++) tick();
    check("err_sticky", err, 1);
    rand_mem();
    run_fft(4'd3, 1'b0, 0, -1, -1);

    // reset during stage 1
    rand_mem();
    begin_run(4'd3, 1'b0, 0, lg);
    guard = 0;
    while ((cyc - t0) < 8 && guard < 50) begin tick(); guard++; end
    check("in_stage1", {busy, rd_en}, 2'b11);
    rst_n = 1'b0; mon_en = 1'b0;
    tick();
    check("midrst_outs", {busy, done, rd_en, bf_enable, wr_en}, 0);
    check("midrst_state", fsm_state, ST_IDLE);
    rst_n = 1'b1;
    wr_any = 0;
    for (int i = 0; i < 30; i++) tick();
    check("midrst_no_wr", wr_any, 0);
    check("midrst_idle", busy, 0);

    // randomized sizes (including clamped values) and directions
    for (int r = 0; r < 6; r++) begin
      rand_mem();
      run_fft(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
